// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU command sequencer: command word layout,
// sequencer state encoding and ALSU opcode values.
package alsu_pkg;

   localparam int CMD_W  = 16;
   localparam int OUT_W  = 6;
   localparam int LEDS_W = 16;

   localparam int A_LSB     = 0;
   localparam int B_LSB     = 3;
   localparam int OPC_LSB   = 6;
   localparam int CIN_BIT   = 9;
   localparam int SER_BIT   = 10;
   localparam int RED_A_BIT = 11;
   localparam int RED_B_BIT = 12;
   localparam int BYP_A_BIT = 13;
   localparam int BYP_B_BIT = 14;
   localparam int DIR_BIT   = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   typedef enum logic [2:0] {
      OP_AND    = 3'd0,
      OP_XOR    = 3'd1,
      OP_ADD    = 3'd2,
      OP_MUL    = 3'd3,
      OP_SHIFT  = 3'd4,
      OP_ROTATE = 3'd5
   } alsu_opcode_t;

   typedef struct packed {
      logic       direction;
      logic       bypass_b;
      logic       bypass_a;
      logic       red_op_b;
      logic       red_op_a;
      logic       serial_in;
      logic       cin;
      logic [2:0] opcode;
      logic [2:0] b;
      logic [2:0] a;
   } alsu_cmd_t;

   // Field extraction by named bit positions so the struct order never has
   // to track the wire format by accident.
   function automatic alsu_cmd_t decode_cmd(input logic [CMD_W-1:0] w);
      alsu_cmd_t c;
      c.a         = w[A_LSB +: 3];
      c.b         = w[B_LSB +: 3];
      c.opcode    = w[OPC_LSB +: 3];
      c.cin       = w[CIN_BIT];
      c.serial_in = w[SER_BIT];
      c.red_op_a  = w[RED_A_BIT];
      c.red_op_b  = w[RED_B_BIT];
      c.bypass_a  = w[BYP_A_BIT];
      c.bypass_b  = w[BYP_B_BIT];
      c.direction = w[DIR_BIT];
      return c;
   endfunction

endpackage

// File: rtl/alsu_cmd_sequencer_fifo.sv
// Small synchronous FIFO with a combinational head read, used as the command
// queue in front of the ALSU sequencer.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push, do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign dout  = mem[rd_ptr_reg];
   assign count = count_reg;
   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);

endmodule

// File: rtl/alsu_cmd_sequencer.sv
// Feeds queued command words to the ALSU one at a time, waits out its
// registered latency and returns one captured result per command.
module alsu_cmd_sequencer
   import alsu_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int ALSU_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_cmd,
   output logic [2:0]  alsu_A,
   output logic [2:0]  alsu_B,
   output logic [2:0]  alsu_opcode,
   output logic        alsu_cin,
   output logic        alsu_serial_in,
   output logic        alsu_red_op_A,
   output logic        alsu_red_op_B,
   output logic        alsu_bypass_A,
   output logic        alsu_bypass_B,
   output logic        alsu_direction,
   input  logic [5:0]  alsu_out,
   input  logic [15:0] alsu_leds,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [5:0]  res_data,
   output logic        res_err,
   output logic        busy
);

   localparam int CNT_W = (ALSU_LAT < 1) ? 1 : $clog2(ALSU_LAT + 1);
   localparam int CW    = $clog2(DEPTH) + 1;

   seq_state_t       state_reg, state_next;
   alsu_cmd_t        drv_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             res_valid_reg;
   logic             res_err_reg;
   logic [5:0]       res_data_reg;

   logic             push, pop, capture, release_res;
   logic [CMD_W-1:0] fifo_head;
   logic [CW-1:0]    fifo_count;
   logic             fifo_full, fifo_empty;

   assign in_ready = ~fifo_full;
   assign push     = in_valid & in_ready;

   sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (in_cmd),
      .dout  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (cnt_reg == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_next = fifo_empty ? IDLE : WAIT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Strobes decoded from state and handshakes; a pop out of DONE happens in
   // the same edge the held result is released.
   always_comb begin
      pop         = 1'b0;
      capture     = 1'b0;
      release_res = 1'b0;
      busy        = (state_reg != IDLE) || (fifo_count != '0);
      case (state_reg)
         IDLE: pop = ~fifo_empty;
         WAIT: capture = (cnt_reg == '0);
         DONE: begin
            release_res = res_ready;
            pop         = res_ready & ~fifo_empty;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drv_reg <= '0;
         cnt_reg <= '0;
      end else if (pop) begin
         drv_reg <= decode_cmd(fifo_head);
         cnt_reg <= CNT_W'(ALSU_LAT);
      end else if (state_reg == WAIT && cnt_reg != '0) begin
         cnt_reg <= cnt_reg - CNT_W'(1);
      end
   end

   // Result registers hold until the consumer takes them; the drive
   // registers above are deliberately left holding the last command.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_valid_reg <= 1'b0;
         res_data_reg  <= '0;
         res_err_reg   <= 1'b0;
      end else if (capture) begin
         res_valid_reg <= 1'b1;
         res_data_reg  <= alsu_out;
         res_err_reg   <= |alsu_leds;
      end else if (release_res) begin
         res_valid_reg <= 1'b0;
      end
   end

   assign alsu_A         = drv_reg.a;
   assign alsu_B         = drv_reg.b;
   assign alsu_opcode    = drv_reg.opcode;
   assign alsu_cin       = drv_reg.cin;
   assign alsu_serial_in = drv_reg.serial_in;
   assign alsu_red_op_A  = drv_reg.red_op_a;
   assign alsu_red_op_B  = drv_reg.red_op_b;
   assign alsu_bypass_A  = drv_reg.bypass_a;
   assign alsu_bypass_B  = drv_reg.bypass_b;
   assign alsu_direction = drv_reg.direction;

   assign res_valid = res_valid_reg;
   assign res_data  = res_data_reg;
   assign res_err   = res_err_reg;

endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// Directed bench for alsu_cmd_sequencer driving a behavioural two-stage ALSU.
module tb_alsu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_cmd = '0;
   logic [2:0]  alsu_A, alsu_B, alsu_opcode;
   logic        alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
   logic        alsu_bypass_A, alsu_bypass_B, alsu_direction;
   logic [5:0]  alsu_out;
   logic [15:0] alsu_leds;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [5:0]  res_data;
   logic        res_err;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alsu_cmd_sequencer #(.DEPTH(4), .ALSU_LAT(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_cmd         (in_cmd),
      .alsu_A         (alsu_A),
      .alsu_B         (alsu_B),
      .alsu_opcode    (alsu_opcode),
      .alsu_cin       (alsu_cin),
      .alsu_serial_in (alsu_serial_in),
      .alsu_red_op_A  (alsu_red_op_A),
      .alsu_red_op_B  (alsu_red_op_B),
      .alsu_bypass_A  (alsu_bypass_A),
      .alsu_bypass_B  (alsu_bypass_B),
      .alsu_direction (alsu_direction),
      .alsu_out       (alsu_out),
      .alsu_leds      (alsu_leds),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_data       (res_data),
      .res_err        (res_err),
      .busy           (busy)
   );

   // Behavioural ALSU: input register stage, then output register stage.
   logic [2:0] ma, mb, mop;
   logic       mcin, mser, mra, mrb, mba, mbb, mdir, minv;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         {ma, mb, mop, mcin, mser, mra, mrb, mba, mbb, mdir} <= '0;
      end else begin
         ma <= alsu_A;  mb <= alsu_B;  mop <= alsu_opcode;
         mcin <= alsu_cin;  mser <= alsu_serial_in;
         mra <= alsu_red_op_A;  mrb <= alsu_red_op_B;
         mba <= alsu_bypass_A;  mbb <= alsu_bypass_B;  mdir <= alsu_direction;
      end
   end

   assign minv = (mop == 3'd6) || (mop == 3'd7) || ((mra || mrb) && (mop > 3'd1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alsu_out  <= '0;
         alsu_leds <= '0;
      end else if (minv) begin
         alsu_out  <= '0;
         alsu_leds <= ~alsu_leds;
      end else begin
         alsu_leds <= '0;
         if (mba)      alsu_out <= {3'b0, ma};
         else if (mbb) alsu_out <= {3'b0, mb};
         else begin
            case (mop)
               3'd0: alsu_out <= mra ? {5'b0, &ma} : mrb ? {5'b0, &mb} : {3'b0, ma & mb};
               3'd1: alsu_out <= mra ? {5'b0, ^ma} : mrb ? {5'b0, ^mb} : {3'b0, ma ^ mb};
               3'd2: alsu_out <= {3'b0, ma} + {3'b0, mb} + {5'b0, mcin};
               3'd3: alsu_out <= {3'b0, ma} * {3'b0, mb};
               3'd4: alsu_out <= mdir ? {alsu_out[4:0], mser} : {mser, alsu_out[5:1]};
               default: alsu_out <= mdir ? {alsu_out[4:0], alsu_out[5]} : {alsu_out[0], alsu_out[5:1]};
            endcase
         end
      end
   end

   logic [15:0] drv_bus;
   assign drv_bus = {alsu_direction, alsu_bypass_B, alsu_bypass_A, alsu_red_op_B,
                     alsu_red_op_A, alsu_serial_in, alsu_cin, alsu_opcode, alsu_B, alsu_A};

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mk_cmd(input logic [2:0] a, input logic [2:0] b,
                                          input logic [2:0] op, input logic red_a);
      logic [15:0] c;
      c = '0;
      c[2:0]  = a;
      c[5:3]  = b;
      c[8:6]  = op;
      c[11]   = red_a;
      return c;
   endfunction

   // Offer one command from a negedge; returns at the negedge after acceptance.
   task automatic send(input logic [15:0] cmd);
      int i;
      in_valid = 1'b1;
      in_cmd   = cmd;
      i = 0;
      while (!in_ready && i < 40) begin
         @(negedge clk);
         i++;
      end
      if (!in_ready) check_val("send_timeout", {15'b0, in_ready}, 16'd1);
      @(negedge clk);
      in_valid = 1'b0;
      $display("push cmd=0x%04h", cmd);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!res_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!res_valid) check_val("res_valid_timeout", {15'b0, res_valid}, 16'd1);
      $display("result data=%0d err=%0b after %0d cycles", res_data, res_err, lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int lat, lat2, acc, seen;

      // Reset with a command offered: nothing may be taken in.
      in_valid = 1'b1;
      in_cmd   = 16'hFFFF;
      repeat (3) @(negedge clk);
      check_val("rst_res_valid", {15'b0, res_valid}, 16'd0);
      check_val("rst_drv_bus", drv_bus, 16'h0000);
      check_val("rst_in_ready", {15'b0, in_ready}, 16'd1);
      check_val("rst_busy", {15'b0, busy}, 16'd0);
      check_val("rst_res_data", {10'b0, res_data}, 16'd0);
      check_val("rst_res_err", {15'b0, res_err}, 16'd0);
      rst      = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_val("post_rst_busy", {15'b0, busy}, 16'd0);

      // Single ADD 3+5
      send(mk_cmd(3'd3, 3'd5, 3'd2, 1'b0));
      wait_valid(lat);
      check_val("add_latency", 16'(lat), 16'd4);
      check_val("add_data", {10'b0, res_data}, 16'd8);
      check_val("add_err", {15'b0, res_err}, 16'd0);
      check_val("add_drv_hold", drv_bus, 16'h00AB);
      res_ready = 1'b1;
      @(negedge clk);
      check_val("add_release", {15'b0, res_valid}, 16'd0);

      // Back-to-back MUL 7*6 then AND 6&3
      send(mk_cmd(3'd7, 3'd6, 3'd3, 1'b0));
      send(mk_cmd(3'd6, 3'd3, 3'd0, 1'b0));
      wait_valid(lat);
      check_val("b2b_mul", {10'b0, res_data}, 16'd42);
      @(negedge clk);
      check_val("b2b_pulse", {15'b0, res_valid}, 16'd0);
      wait_valid(lat2);
      check_val("b2b_gap", 16'(lat2 + 1), 16'd4);
      check_val("b2b_and", {10'b0, res_data}, 16'd2);
      @(negedge clk);
      res_ready = 1'b0;

      // Backpressure: six offers, ADD k+1 plus 1
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1;
         in_cmd   = mk_cmd(3'(k + 1), 3'd1, 3'd2, 1'b0);
         $display("offer cmd=0x%04h ready=%0b", in_cmd, in_ready);
         if (in_ready) acc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check_val("bp_accepted", 16'(acc), 16'd5);
      repeat (6) @(negedge clk);
      check_val("bp_in_ready", {15'b0, in_ready}, 16'd0);
      check_val("bp_held_valid", {15'b0, res_valid}, 16'd1);
      check_val("bp_held_data", {10'b0, res_data}, 16'd2);
      res_ready = 1'b1;
      for (int r = 0; r < 5; r++) begin
         wait_valid(lat);
         check_val("bp_result", {10'b0, res_data}, 16'(r + 2));
         @(negedge clk);
         if (r == 0) check_val("bp_ready_back", {15'b0, in_ready}, 16'd1);
      end
      check_val("bp_drained_busy", {15'b0, busy}, 16'd0);

      // Invalid op: ADD with red_op_A
      send(mk_cmd(3'd3, 3'd5, 3'd2, 1'b1));
      wait_valid(lat);
      check_val("inv_data", {10'b0, res_data}, 16'd0);
      check_val("inv_err", {15'b0, res_err}, 16'd1);
      @(negedge clk);
      res_ready = 1'b0;

      // Reset while one command is in flight and two are queued
      send(mk_cmd(3'd1, 3'd2, 3'd2, 1'b0));
      send(mk_cmd(3'd2, 3'd2, 3'd2, 1'b0));
      send(mk_cmd(3'd3, 3'd2, 3'd2, 1'b0));
      check_val("mid_pre_busy", {15'b0, busy}, 16'd1);
      rst = 1'b0;
      @(negedge clk);
      check_val("mid_rst_busy", {15'b0, busy}, 16'd0);
      check_val("mid_rst_drv", drv_bus, 16'h0000);
      rst = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (res_valid) seen++;
      end
      check_val("mid_no_result", 16'(seen), 16'd0);
      check_val("mid_busy", {15'b0, busy}, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alsu_cmd_sequencer.md
Name: alsu_cmd_sequencer

Overview:
- Upstream feeder for the ALSU: accepts packed 16-bit command words over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the ALSU input pins and holds it for the ALSU's registered latency.
- Captures out/leds at a fixed cycle and presents one result per command over a valid/ready result port.
- Sits between the stimulus/host side and the ALSU; the ALSU itself is unchanged.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- ALSU_LAT, 2, ALSU clock edges from input pins to valid out (input register + output register)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  command word offered
- in_ready  out  1  FIFO can accept this cycle
- in_cmd  in  16  [2:0] A, [5:3] B, [8:6] opcode, [9] cin, [10] serial_in, [11] red_op_A, [12] red_op_B, [13] bypass_A, [14] bypass_B, [15] direction
- alsu_A, alsu_B, alsu_opcode  out  3 each  registered drive to ALSU
- alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction  out  1 each  registered drive to ALSU
- alsu_out  in  6  ALSU result
- alsu_leds  in  16  ALSU error LEDs
- res_valid  out  1  result held
- res_ready  in  1  consumer accepts
- res_data  out  6  captured alsu_out
- res_err  out  1  reduction-OR of alsu_leds at capture
- busy  out  1  state ≠ IDLE or FIFO non-empty

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied, state IDLE.
  - All alsu_* drive registers = 0.
  - res_valid = 0, res_data = 0, res_err = 0, busy = 0.
  - in_ready = 1 (count = 0).
- Push: in_valid && in_ready at an edge. in_ready = (count < DEPTH), with no full-bypass. While full, a pop and an offered push in the same cycle still see in_ready = 0.
- Pop: always the head entry. Loads all drive registers in one edge and sets wait counter cnt = ALSU_LAT.
- FSM states IDLE, WAIT, DONE:
  - IDLE: if count > 0, pop → WAIT. The FIFO is never bypassed, so a push at edge p pops at edge p+1 at the earliest.
  - WAIT: if cnt ≠ 0, decrement. If cnt = 0, capture res_data ← alsu_out and res_err ← |alsu_leds, set res_valid = 1 → DONE.
  - DONE: res_valid held and res_data/res_err stable until res_ready = 1 at an edge.
    - At that edge res_valid clears.
    - If count > 0, pop in the same edge → WAIT (back-to-back); else → IDLE.
- Latency:
  - Pop at edge k → capture at edge k + ALSU_LAT + 1.
  - Accept to res_valid = ALSU_LAT + 2 edges when idle.
  - Steady-state throughput is one result per ALSU_LAT + 2 cycles with res_ready tied high.
- Drive registers keep the last command after capture. Shift opcodes (4/5) keep shifting inside the ALSU, but that does not affect the captured result.
- Simultaneous push and pop: count unchanged, entry order preserved. Pointers wrap modulo DEPTH.
- Reset mid-operation: in-flight command and queued entries are discarded; no result emerges after release.
- Width rules: res_data is exactly the 6-bit alsu_out, with no extension or truncation.

Decomposition:
- Shared package alsu_pkg holds:
  - command field bit-position constants (A_LSB … DIR_BIT)
  - FSM state encoding (IDLE = 0, WAIT = 1, DONE = 2)
  - opcode constants (AND = 0, XOR = 1, ADD = 2, MUL = 3, SHIFT = 4, ROTATE = 5)
- One sub-module: sync_fifo (parameterised width/depth, async active-low reset, push/pop/count/full/empty).
- Sequencer FSM and capture logic stay in the top.

Test Plan:
- Bench instantiates the ALSU with default parameters, driven by this block.
- Reset check: rst = 0 with in_valid = 1 → res_valid = 0, all alsu_* = 0, in_ready = 1, busy = 0; nothing is accepted while rst = 0.
- Single ADD: cmd A = 3, B = 5, opcode = 2, cin = 0, rest 0, accepted at edge p → res_valid rises after edge p+4, res_data = 8, res_err = 0.
- Back-to-back: MUL A = 7, B = 6, then AND A = 6, B = 3, res_ready = 1 → res_data 42, then 2, with res_valid pulses exactly 4 cycles apart.
- Backpressure: res_ready = 0, offer 6 commands consecutively → 5 accepted (1 in flight + 4 queued), in_ready = 0 from then on.
  - Release res_ready → 5 results in push order, in_ready returns on first pop.
- Invalid op: opcode = 2 with red_op_A = 1 → res_err = 1, res_data = 0.
- Mid-operation reset: pulse rst low for 1 cycle during WAIT with 2 queued → res_valid stays 0, busy = 0, no results for 10 cycles after release.
